plot_arbiter: RTL and testbench
===============================

# plot_arbiter

Shares the single plot port of the 320x240 monochrome VGA frame adapter between several pixel producers: the bdiff image scanner, the centroid-marker drawer and future overlays. Each requester gets exclusive, bounded-length bursts under round-robin arbitration. Accepted pixels are forwarded to the adapter as registered `vga_plot`/`vga_x`/`vga_y`/`vga_colour`.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `MAX_BURST`, default 16: maximum pixels accepted per grant, 1..255.
- `COLOUR_BITS`, default 1: colour width per pixel.
- `clock` input 1: system clock (50 MHz).
- `resetn` input 1: asynchronous, active-low reset.
- `req` input NUM_REQ: per-requester request; bit i is held high while requester i has a pixel presented.
- `last` input NUM_REQ: bit i marks the presented pixel as the final pixel of requester i's burst.
- `px_x` input NUM_REQ*9: packed x coordinates; slice i belongs to requester i.
- `px_y` input NUM_REQ*8: packed y coordinates.
- `px_colour` input NUM_REQ*COLOUR_BITS: packed colours.
- `gnt` output NUM_REQ: registered, one-hot or zero; bit i set means requester i owns the port.
- `vga_plot` output 1: registered plot strobe to the adapter.
- `vga_x` output 9: registered x coordinate.
- `vga_y` output 8: registered y coordinate.
- `vga_colour` output COLOUR_BITS: registered colour.

## Operation
- The FSM has two states, ARB and BURST. A round-robin pointer `rr_ptr` (0..NUM_REQ-1) and a burst counter `bcnt` (8 bits) support it.
- ARB state:
  - If any `req` bit is set, the winner is the first set bit at or after `rr_ptr`, searching upward with wrap.
  - On the winner being chosen: `gnt` is set to the one-hot of the winner, `bcnt` is set to 0, and the FSM moves to BURST.
  - If no `req` bit is set, the FSM stays in ARB.
- BURST state, with owner w:
  - A pixel is accepted on every edge where `req[w]` and `gnt[w]` are both high.
  - On acceptance, slice w of `px_x`, `px_y` and `px_colour` is captured, and `bcnt` is incremented.
  - Release happens on the first edge where any of these holds:
    - an accepted pixel has `last[w]` set;
    - an accepted pixel makes `bcnt` reach MAX_BURST;
    - `req[w]` is low.
  - On release: `gnt` is set to 0, `rr_ptr` is set to (w+1) mod NUM_REQ, and the FSM returns to ARB. The final accepted pixel is still plotted.
  - `last` and the MAX_BURST limit occurring on the same pixel cause a single release.
- Requesters change their presented pixel only after an edge on which they saw `req & gnt`.
- Requests from non-owners are ignored during BURST, and their `last` bits are don't-care.
- Coordinate arithmetic is unsigned. Coordinates pass through unmodified, except where clipping applies (see Configuration).

## Timing
- Reset (asynchronous assert, synchronous release), all to zero:
  - `gnt`=0, `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0;
  - state ARB, `rr_ptr`=0, `bcnt`=0.
- Reset asserted mid-burst drops the burst and any pixel in flight. No plot occurs after reset asserts.
- Grant latency: `req` high at edge N in ARB gives `gnt` high after edge N. The first acceptance is at edge N+1.
- Pixel latency: a pixel accepted at edge K drives `vga_plot`=1 with its data for the cycle after edge K.
- `vga_plot` is 0 in every cycle following an edge with no acceptance. `vga_x`, `vga_y` and `vga_colour` hold their last values while it is 0.
- Peak throughput is one pixel per clock within a burst. Every release costs one ARB cycle before the next grant.
- Fairness: a requester waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles of other owners' bursts, plus the time for other owners to assert `req`.

## Configuration
- `PLOT_ARBITER_CLIP_EN`:
  - When defined, an accepted pixel with x>=320 or y>=240 is consumed: it counts toward `bcnt` and honours `last`. It produces `vga_plot`=0 in the following cycle, and the data registers are not updated.
  - When undefined, every accepted pixel is plotted unchanged. Off-screen rejection is then the adapter's responsibility.

## Structure
- The shared package `motion_pkg` holds:
  - the constants IMAGE_W=320, IMAGE_H=240, X_WIDTH=9, Y_WIDTH=8;
  - the FSM state typedef (ARB, BURST).
- The sub-module `rr_picker` is a combinational round-robin select. Inputs: `req` and `rr_ptr`. Outputs: winner index and `any`. It is instantiated once, in the ARB path.

## Test plan
- Single requester: req[0] held, 5 pixels (1,1)..(5,1) with `last` on the 5th, colour 1.
  - gnt[0]=1 one cycle after req.
  - 5 consecutive `vga_plot` pulses with x=1..5.
  - gnt returns to 0, and rr_ptr becomes 1.
- All three requesters hold req, no `last`, MAX_BURST=16.
  - Grant order is 0, 1, 2, 0.
  - Each burst is exactly 16 plots.
  - There is one idle `vga_plot`=0 cycle between bursts.
- Owner 1 drops req after 3 accepted pixels, without `last`.
  - Release follows with 3 plots.
  - The next grant goes to requester 2 when req[2] is high.
- `last` asserted on the 16th pixel with MAX_BURST=16.
  - Exactly one release.
  - rr_ptr advances by one only.
- With `PLOT_ARBITER_CLIP_EN` defined: pixels (319,239), (320,0), (0,240).
  - Only the first produces `vga_plot`=1.
  - `bcnt` counts all three.
- resetn pulsed low mid-burst after 2 of 8 pixels.
  - All outputs are 0 immediately.
  - FSM in ARB with rr_ptr=0.
  - Re-arbitration starts from requester 0 after release.

Source files
------------

// File: rtl/motion_pkg.sv
// motion_pkg: shared constants and types for the motion-detection display path.
//
// Contents:
//   IMAGE_W / IMAGE_H  visible frame size of the VGA adapter (320x240)
//   X_WIDTH / Y_WIDTH  coordinate widths on the plot port (9 / 8 bits)
//   BCNT_W             width of the per-grant burst counter
//   arb_state_t        plot_arbiter FSM states (ARB, BURST)
package motion_pkg;

    localparam int IMAGE_W = 320;
    localparam int IMAGE_H = 240;
    localparam int X_WIDTH = 9;
    localparam int Y_WIDTH = 8;
    localparam int BCNT_W  = 8;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin select.
//
// Returns the first set request bit at or after the pointer, searching upward
// and wrapping past NUM_REQ-1 back to 0.
//
// Ports:
//   req_i     [NUM_REQ-1:0]  request vector
//   rr_ptr_i  [PTR_W-1:0]    search start index (0..NUM_REQ-1)
//   winner_o  [PTR_W-1:0]    index of the selected requester (0 when any_o=0)
//   any_o                    at least one request bit is set
module rr_picker
    import motion_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [PTR_W-1:0]   winner_o,
    output logic               any_o
);

    logic [PTR_W-1:0] idx;

    // Walk the candidates from farthest to nearest so the nearest set bit
    // (smallest distance from the pointer) is the last one written.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(rr_ptr_i) + k) % NUM_REQ);
            if (req_i[idx]) begin
                winner_o = idx;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the single plot port of the 320x240 VGA frame adapter
// between several pixel producers using round-robin, bounded-length bursts.
//
// Handshake: requester i holds req[i] high while it presents a pixel on its
// slice of px_x/px_y/px_colour (with last[i] marking the final pixel of its
// burst). A pixel is transferred on every clock edge where req[i] and gnt[i]
// are both high; the requester advances to its next pixel only after such an
// edge. gnt is registered, so a request seen in ARB is granted one cycle later
// and the first transfer happens on the following edge.
//
// Ports:
//   clock, resetn                 clock, asynchronous active-low reset
//   req, last      [NUM_REQ]      per-requester request / end-of-burst marker
//   px_x           [NUM_REQ*9]    packed x coordinates (slice i = requester i)
//   px_y           [NUM_REQ*8]    packed y coordinates
//   px_colour      [NUM_REQ*CB]   packed colours
//   gnt            [NUM_REQ]      registered one-hot (or zero) grant
//   vga_plot/x/y/colour           registered plot port to the VGA adapter
//   dbg_state_o                   FSM state (0 = ARB, 1 = BURST)
//   dbg_rr_ptr_o                  round-robin pointer
//   dbg_bcnt_o                    pixels accepted in the current/last burst
//
// Build option: define PLOT_ARBITER_CLIP_EN to drop off-screen pixels
// (x >= 320 or y >= 240). Dropped pixels are still consumed: they count toward
// the burst length and honour last, but produce no plot and leave the data
// registers unchanged.
module plot_arbiter
    import motion_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int MAX_BURST   = 16,
    parameter int COLOUR_BITS = 1
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             last,
    input  logic [NUM_REQ*X_WIDTH-1:0]     px_x,
    input  logic [NUM_REQ*Y_WIDTH-1:0]     px_y,
    input  logic [NUM_REQ*COLOUR_BITS-1:0] px_colour,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           vga_plot,
    output logic [X_WIDTH-1:0]             vga_x,
    output logic [Y_WIDTH-1:0]             vga_y,
    output logic [COLOUR_BITS-1:0]         vga_colour,
    output logic                           dbg_state_o,
    output logic [$clog2(NUM_REQ)-1:0]     dbg_rr_ptr_o,
    output logic [BCNT_W-1:0]              dbg_bcnt_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t               state_q, state_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]         owner_q, owner_d;
    logic [BCNT_W-1:0]        bcnt_q, bcnt_d;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d;
    logic                     plot_q, plot_d;
    logic [X_WIDTH-1:0]       x_q, x_d;
    logic [Y_WIDTH-1:0]       y_q, y_d;
    logic [COLOUR_BITS-1:0]   col_q, col_d;

    logic [PTR_W-1:0]         winner;
    logic                     any_req;
    logic [X_WIDTH-1:0]       sel_x;
    logic [Y_WIDTH-1:0]       sel_y;
    logic [COLOUR_BITS-1:0]   sel_c;
    logic                     accept;
    logic                     on_screen;
    logic [BCNT_W:0]          bcnt_inc;
    logic                     hit_max;
    logic [PTR_W-1:0]         next_ptr;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    // Owner's presented pixel.
    assign sel_x = px_x[owner_q*X_WIDTH +: X_WIDTH];
    assign sel_y = px_y[owner_q*Y_WIDTH +: Y_WIDTH];
    assign sel_c = px_colour[owner_q*COLOUR_BITS +: COLOUR_BITS];

    assign accept = (state_q == BURST) && req[owner_q] && gnt_q[owner_q];

    // One extra bit so MAX_BURST=255 compares without wrapping.
    assign bcnt_inc = {1'b0, bcnt_q} + {{BCNT_W{1'b0}}, 1'b1};
    assign hit_max  = (bcnt_inc == (BCNT_W+1)'(MAX_BURST));

    assign next_ptr = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

`ifdef PLOT_ARBITER_CLIP_EN
    assign on_screen = (sel_x < X_WIDTH'(IMAGE_W)) && (sel_y < Y_WIDTH'(IMAGE_H));
`else
    assign on_screen = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        bcnt_d   = bcnt_q;
        gnt_d    = gnt_q;
        plot_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        col_d    = col_q;

        case (state_q)
            ARB: begin
                if (any_req) begin
                    owner_d = winner;
                    gnt_d   = NUM_REQ'(1) << winner;
                    bcnt_d  = '0;
                    state_d = BURST;
                end
            end

            BURST: begin
                if (accept) begin
                    bcnt_d = bcnt_inc[BCNT_W-1:0];
                    if (on_screen) begin
                        plot_d = 1'b1;
                        x_d    = sel_x;
                        y_d    = sel_y;
                        col_d  = sel_c;
                    end
                    // last and the burst limit on the same pixel fold into
                    // one release because both feed the same branch.
                    if (last[owner_q] || hit_max) begin
                        gnt_d    = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = ARB;
                    end
                end else begin
                    // Owner withdrew its request without marking last.
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = ARB;
                end
            end

            default: begin
                state_d = ARB;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            bcnt_q   <= '0;
            gnt_q    <= '0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            col_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            bcnt_q   <= bcnt_d;
            gnt_q    <= gnt_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            col_q    <= col_d;
        end
    end

    assign gnt          = gnt_q;
    assign vga_plot     = plot_q;
    assign vga_x        = x_q;
    assign vga_y        = y_q;
    assign vga_colour   = col_q;
    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;
    assign dbg_bcnt_o   = bcnt_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed scoreboard bench for plot_arbiter (3 requesters,
// MAX_BURST=16, 1-bit colour). Requesters are modelled as pixel lists that
// advance after every edge seeing req&gnt; expected plots are pushed in
// hand-derived grant order and checked by an independent monitor.
// Define PLOT_ARBITER_CLIP_EN for both bench and RTL to run the clipping case.
module tb_plot_arbiter;
    import motion_pkg::*;

    localparam int NR = 3;
    localparam int MB = 16;
    localparam int CB = 1;
    localparam int PW = 2;
    localparam int W  = X_WIDTH + Y_WIDTH + CB;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic       c;
        logic       lst;
    } pix_t;

    // ---------------- clock / reset ----------------
    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     last = '0;
    logic [NR*9-1:0]   px_x = '0;
    logic [NR*8-1:0]   px_y = '0;
    logic [NR*CB-1:0]  px_colour = '0;
    logic [NR-1:0]     gnt;
    logic              vga_plot;
    logic [8:0]        vga_x;
    logic [7:0]        vga_y;
    logic [CB-1:0]     vga_colour;
    logic              dbg_state;
    logic [PW-1:0]     dbg_rr_ptr;
    logic [7:0]        dbg_bcnt;

    always #10 clock = ~clock;

    plot_arbiter #(
        .NUM_REQ     (NR),
        .MAX_BURST   (MB),
        .COLOUR_BITS (CB)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .req          (req),
        .last         (last),
        .px_x         (px_x),
        .px_y         (px_y),
        .px_colour    (px_colour),
        .gnt          (gnt),
        .vga_plot     (vga_plot),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .dbg_state_o  (dbg_state),
        .dbg_rr_ptr_o (dbg_rr_ptr),
        .dbg_bcnt_o   (dbg_bcnt)
    );

    // ---------------- bench state ----------------
    pix_t        src_mem [NR][128];
    int          src_head [NR];
    int          src_cnt [NR];
    logic [W-1:0] exp_q[$];
    int          plot_cyc_q[$];
    int          gnt_log[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          plot_cnt = 0;
    logic [NR-1:0] hs_seen;
    logic [NR-1:0] prev_gnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic update_drive();
        for (int i = 0; i < NR; i++) begin
            if (src_head[i] < src_cnt[i]) begin
                req[i]              = 1'b1;
                last[i]             = src_mem[i][src_head[i]].lst;
                px_x[i*9 +: 9]      = src_mem[i][src_head[i]].x;
                px_y[i*8 +: 8]      = src_mem[i][src_head[i]].y;
                px_colour[i*CB +: CB] = src_mem[i][src_head[i]].c;
            end else begin
                req[i]  = 1'b0;
                last[i] = 1'b0;
            end
        end
    endtask

    task automatic load(input int r, input int x, input int y, input int c, input bit lst);
        pix_t p;
        p.x   = x[8:0];
        p.y   = y[7:0];
        p.c   = c[0];
        p.lst = lst;
        src_mem[r][src_cnt[r]] = p;
        src_cnt[r]++;
    endtask

    task automatic push_exp(input int x, input int y, input int c);
        logic [8:0] ex;
        logic [7:0] ey;
        logic       ec;
        ex = x[8:0];
        ey = y[7:0];
        ec = c[0];
        exp_q.push_back({ex, ey, ec});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #2;
    endtask

    function automatic bit srcs_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NR; i++)
            if (src_head[i] < src_cnt[i]) e = 1'b0;
        return e;
    endfunction

    task automatic wait_drain(input string name, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (exp_q.size() == 0 && srcs_empty() && gnt == '0) begin
                done = 1'b1;
                break;
            end
            tick(1);
        end
        check({name, "_drain"}, done, 1);
        tick(3);
        check({name, "_exp_empty"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < NR; i++) begin
            src_head[i] = 0;
            src_cnt[i]  = 0;
        end
        exp_q.delete();
        update_drive();
        tick(2);
        check("rst_gnt", gnt, 0);
        check("rst_plot", vga_plot, 0);
        resetn = 1'b1;
        tick(1);
    endtask

    // Requester model: advance on an edge that saw req & gnt (pre-edge values).
    always @(posedge clock) begin
        cyc++;
        hs_seen = req & gnt;
        #1;
        for (int i = 0; i < NR; i++)
            if (hs_seen[i] && src_head[i] < src_cnt[i]) src_head[i]++;
        update_drive();
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [W-1:0] got;
        logic [W-1:0] expv;
        if (vga_plot) begin
            plot_cnt++;
            plot_cyc_q.push_back(cyc);
            got = {vga_x, vga_y, vga_colour};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, required no plot",
                         vga_x, vga_y, vga_colour);
            end else begin
                expv = exp_q.pop_front();
                check("plot_pixel", got, expv);
            end
        end
        check("gnt_onehot", ($countones(gnt) <= 1), 1);
        if (gnt != '0 && prev_gnt == '0) begin
            for (int i = 0; i < NR; i++)
                if (gnt[i]) gnt_log.push_back(i);
        end
        prev_gnt = gnt;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int pb;
        int gb;
        int pc;
        bit reached;

        for (int i = 0; i < NR; i++) begin
            src_head[i] = 0;
            src_cnt[i]  = 0;
        end

        // Reset state.
        #5;
        check("reset_gnt", gnt, 0);
        check("reset_plot", vga_plot, 0);
        check("reset_x", vga_x, 0);
        check("reset_y", vga_y, 0);
        check("reset_colour", vga_colour, 0);
        check("reset_state", dbg_state, 0);
        check("reset_rr_ptr", dbg_rr_ptr, 0);
        check("reset_bcnt", dbg_bcnt, 0);
        tick(2);
        resetn = 1'b1;
        tick(1);

        // Single requester, 5 pixels, last on the 5th.
        pb = plot_cnt;
        gb = gnt_log.size();
        for (int n = 1; n <= 5; n++) begin
            load(0, n, 1, 1, n == 5);
            push_exp(n, 1, 1);
        end
        update_drive();
        tick(1);
        check("t1_gnt_latency", gnt, 1);
        check("t1_state_burst", dbg_state, 1);
        check("t1_no_plot_yet", vga_plot, 0);
        wait_drain("t1", 40);
        check("t1_plots", plot_cnt - pb, 5);
        check("t1_back_to_back", plot_cyc_q[pb+4] - plot_cyc_q[pb], 4);
        check("t1_gnt_released", gnt, 0);
        check("t1_rr_ptr", dbg_rr_ptr, 1);
        check("t1_state_arb", dbg_state, 0);
        check("t1_grants", gnt_log.size() - gb, 1);

        // Three requesters, no last: MAX_BURST-limited rotation.
        do_reset();
        pb = plot_cnt;
        gb = gnt_log.size();
        for (int r = 0; r < NR; r++)
            for (int n = 0; n < 32; n++)
                load(r, r*64 + n, n, n % 2, 1'b0);
        for (int ps = 0; ps < 2; ps++)
            for (int r = 0; r < NR; r++)
                for (int n = ps*16; n < ps*16 + 16; n++)
                    push_exp(r*64 + n, n, n % 2);
        update_drive();
        wait_drain("t2", 300);
        check("t2_plots", plot_cnt - pb, 96);
        check("t2_grants", gnt_log.size() - gb, 6);
        check("t2_order0", gnt_log[gb], 0);
        check("t2_order1", gnt_log[gb+1], 1);
        check("t2_order2", gnt_log[gb+2], 2);
        check("t2_order3", gnt_log[gb+3], 0);
        check("t2_burst_run", plot_cyc_q[pb+15] - plot_cyc_q[pb], 15);
        check("t2_idle_gap", plot_cyc_q[pb+16] - plot_cyc_q[pb+15], 2);
        check("t2_span", plot_cyc_q[pb+95] - plot_cyc_q[pb], 100);

        // Owner 1 drops req after 3 pixels without last; requester 2 next.
        do_reset();
        pb = plot_cnt;
        gb = gnt_log.size();
        for (int n = 0; n < 3; n++) load(1, 10 + n, 3, 1, 1'b0);
        load(2, 20, 4, 0, 1'b0);
        load(2, 21, 4, 0, 1'b1);
        for (int n = 0; n < 3; n++) push_exp(10 + n, 3, 1);
        push_exp(20, 4, 0);
        push_exp(21, 4, 0);
        update_drive();
        wait_drain("t3", 40);
        check("t3_plots", plot_cnt - pb, 5);
        check("t3_first_owner", gnt_log[gb], 1);
        check("t3_next_owner", gnt_log[gb+1], 2);
        check("t3_drop_gap", plot_cyc_q[pb+3] - plot_cyc_q[pb+2], 3);
        check("t3_rr_ptr", dbg_rr_ptr, 0);

        // last on the 16th pixel with MAX_BURST=16: one release only.
        do_reset();
        pb = plot_cnt;
        gb = gnt_log.size();
        for (int n = 0; n < 16; n++) begin
            load(0, 100 + n, 5, 1, n == 15);
            push_exp(100 + n, 5, 1);
        end
        update_drive();
        wait_drain("t4", 60);
        check("t4_plots", plot_cnt - pb, 16);
        check("t4_grants", gnt_log.size() - gb, 1);
        check("t4_rr_ptr", dbg_rr_ptr, 1);
        check("t4_bcnt", dbg_bcnt, 16);
        check("t4_state_arb", dbg_state, 0);

`ifdef PLOT_ARBITER_CLIP_EN
        // Off-screen pixels are consumed but not plotted.
        do_reset();
        pb = plot_cnt;
        load(0, 319, 239, 1, 1'b0);
        load(0, 320, 0, 1, 1'b0);
        load(0, 0, 240, 1, 1'b1);
        push_exp(319, 239, 1);
        update_drive();
        wait_drain("t5", 40);
        check("t5_plots", plot_cnt - pb, 1);
        check("t5_bcnt", dbg_bcnt, 3);
        check("t5_x_held", vga_x, 319);
        check("t5_y_held", vga_y, 239);
        check("t5_rr_ptr", dbg_rr_ptr, 1);
`endif

        // Reset mid-burst after 2 of 8 pixels of requester 2.
        do_reset();
        load(1, 30, 6, 1, 1'b0);
        load(1, 31, 6, 1, 1'b1);
        push_exp(30, 6, 1);
        push_exp(31, 6, 1);
        update_drive();
        wait_drain("t6a", 40);
        check("t6_rr_ptr_pre", dbg_rr_ptr, 2);
        pb = plot_cnt;
        for (int n = 0; n < 8; n++) load(2, 40 + n, 7, 1, n == 7);
        for (int n = 0; n < 4; n++) load(0, 50 + n, 8, 0, n == 3);
        for (int n = 0; n < 3; n++) load(1, 60 + n, 9, 1, n == 2);
        push_exp(40, 7, 1);
        push_exp(41, 7, 1);
        update_drive();
        reached = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (plot_cnt - pb == 2) begin
                reached = 1'b1;
                break;
            end
            tick(1);
        end
        check("t6_two_plots", reached, 1);
        #3;
        resetn = 1'b0;
        #1;
        check("t6_rst_gnt", gnt, 0);
        check("t6_rst_plot", vga_plot, 0);
        check("t6_rst_x", vga_x, 0);
        check("t6_rst_y", vga_y, 0);
        check("t6_rst_colour", vga_colour, 0);
        check("t6_rst_state", dbg_state, 0);
        check("t6_rst_rr_ptr", dbg_rr_ptr, 0);
        check("t6_rst_bcnt", dbg_bcnt, 0);
        check("t6_exp_consumed", exp_q.size(), 0);
        pc = plot_cnt;
        tick(2);
        check("t6_no_plot_in_reset", plot_cnt - pc, 0);
        gb = gnt_log.size();
        for (int n = 0; n < 4; n++) push_exp(50 + n, 8, 0);
        for (int n = 0; n < 3; n++) push_exp(60 + n, 9, 1);
        for (int n = 2; n < 8; n++) push_exp(40 + n, 7, 1);
        resetn = 1'b1;
        wait_drain("t6b", 80);
        check("t6_owner_after_rst", gnt_log[gb], 0);
        check("t6_owner_next", gnt_log[gb+1], 1);
        check("t6_owner_last", gnt_log[gb+2], 2);
        check("t6_plots", plot_cnt - pb, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
